// File: rtl/inst_buffer_pkg.sv
// Core definitions shared by the instruction buffer: fetch/squash payload
// types, default sizing, and a popcount helper used for lane counting.
package inst_buffer_pkg;

  localparam int IBUF_DEPTH        = 16;
  localparam int IBUF_FETCH_WIDTH  = 4;
  localparam int IBUF_DECODE_WIDTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetchEntry_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] target_pc;
  } squashInfo_t;

  // Count of set bits; callers zero-extend narrower lane masks to 32 bits.
  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + 6'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/inst_buffer_ptr.sv
// circ_ptr: circular queue pointer carrying an extra wrap bit above the
// index. Adding n advances modulo 2*DEPTH, so index and wrap bit stay
// consistent without explicit wrap handling (DEPTH is a power of two).
module circ_ptr
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH = IBUF_DEPTH,
  parameter int ADD_W = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clr,
  input  logic [ADD_W-1:0]        i_add,
  output logic [$clog2(DEPTH):0]  o_ptr
);

  localparam int PW = $clog2(DEPTH) + 1;

  logic [PW-1:0] r_ptr;

  // Pointer register: clear wins over advance.
  always_ff @(posedge clk) begin
    if (rst || i_clr) r_ptr <= '0;
    else              r_ptr <= r_ptr + PW'(i_add);
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/inst_buffer.sv
// inst_buffer: fetch-to-decode instruction queue. Up to FETCH_WIDTH entries
// enter per cycle in program order; the oldest DECODE_WIDTH are presented to
// decode. A squash empties the buffer on the next cycle.
// Optional macro INST_BUFFER_BYPASS_EN: when the buffer is empty, fetch lanes
// are forwarded to decode in the same cycle.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH        = IBUF_DEPTH,
  parameter int FETCH_WIDTH  = IBUF_FETCH_WIDTH,
  parameter int DECODE_WIDTH = IBUF_DECODE_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_squash_vld,
  input  logic        [FETCH_WIDTH-1:0]        i_enq_vld,
  input  fetchEntry_t [FETCH_WIDTH-1:0]        i_enq_entry,
  output logic                                 o_can_enq,
  output logic        [DECODE_WIDTH-1:0]       o_deq_vld,
  output fetchEntry_t [DECODE_WIDTH-1:0]       o_deq_entry,
  input  logic                                 i_deq_rdy,
  output logic        [$clog2(DEPTH):0]        o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int NW = $clog2(FETCH_WIDTH) + 1;
  localparam int DW = $clog2(DECODE_WIDTH) + 1;

  fetchEntry_t                    r_mem [DEPTH];
  logic        [CW-1:0]           r_count;
  logic        [CW-1:0]           w_count_nxt;
  logic                           r_can_enq;

  logic        [AW:0]             w_head;
  logic        [AW:0]             w_tail;
  logic        [AW-1:0]           w_head_idx;
  logic        [AW-1:0]           w_tail_idx;

  logic                           w_enq_fire;
  logic        [NW-1:0]           w_n_enq;
  logic        [NW-1:0]           w_n_skip;
  logic        [NW-1:0]           w_n_wr;
  logic        [DW-1:0]           w_n_deq;

  logic        [DECODE_WIDTH-1:0] w_st_vld;
  fetchEntry_t [DECODE_WIDTH-1:0] w_st_entry;

  logic                           w_full;
  logic                           w_empty;

  assign w_head_idx = w_head[AW-1:0];
  assign w_tail_idx = w_tail[AW-1:0];
  assign w_full     = (w_head_idx == w_tail_idx) && (w_head[AW] != w_tail[AW]);
  assign w_empty    = (w_head == w_tail);

  // Enqueue only when space was advertised; squash drops the whole group.
  assign w_enq_fire = r_can_enq && (|i_enq_vld) && !i_squash_vld;
  assign w_n_enq    = w_enq_fire ? NW'(popcount(32'(i_enq_vld))) : '0;

  // Oldest DECODE_WIDTH entries straight from registered state.
  always_comb begin
    w_st_vld   = '0;
    w_st_entry = '0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      w_st_vld[i]   = (r_count > CW'(i));
      w_st_entry[i] = r_mem[w_head_idx + AW'(i)];
    end
  end

  // Decode takes every valid stored lane when ready; squash cancels it.
  assign w_n_deq = (i_deq_rdy && !i_squash_vld) ? DW'(popcount(32'(w_st_vld))) : '0;

`ifdef INST_BUFFER_BYPASS_EN
  localparam int BW = (DECODE_WIDTH < FETCH_WIDTH) ? DECODE_WIDTH : FETCH_WIDTH;

  logic                           w_byp_act;
  logic        [DECODE_WIDTH-1:0] w_byp_vld;
  fetchEntry_t [DECODE_WIDTH-1:0] w_byp_entry;

  assign w_byp_act = (r_count == '0) && !i_squash_vld;

  // Forward the fetch lanes that fit in the decode window.
  always_comb begin
    w_byp_vld   = '0;
    w_byp_entry = '0;
    for (int i = 0; i < BW; i++) begin
      w_byp_vld[i]   = i_enq_vld[i];
      w_byp_entry[i] = i_enq_entry[i];
    end
  end

  // Output mux: forwarded lanes when empty, storage otherwise.
  always_comb begin
    o_deq_vld   = w_st_vld;
    o_deq_entry = w_st_entry;
    if (w_byp_act) begin
      o_deq_vld   = w_byp_vld;
      o_deq_entry = w_byp_entry;
    end
  end

  // Lanes consumed by decode in the forwarding cycle never reach storage.
  assign w_n_skip = (w_byp_act && i_deq_rdy && w_enq_fire)
                  ? NW'(popcount(32'(w_byp_vld))) : '0;
`else
  assign o_deq_vld   = w_st_vld;
  assign o_deq_entry = w_st_entry;
  assign w_n_skip    = '0;
`endif

  assign w_n_wr = w_n_enq - w_n_skip;

  // Storage write: lanes skip..n_enq-1 land at tail onward, in order.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (!rst && (NW'(i) >= w_n_skip) && (NW'(i) < w_n_enq))
        r_mem[w_tail_idx + AW'(i) - AW'(w_n_skip)] <= i_enq_entry[i];
    end
  end

  assign w_count_nxt = i_squash_vld ? '0
                     : (r_count + CW'(w_n_wr) - CW'(w_n_deq));

  // Occupancy and the conservative space flag both track count_next.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count   <= '0;
      r_can_enq <= 1'b1;
    end else begin
      r_count   <= w_count_nxt;
      r_can_enq <= (CW'(DEPTH) - w_count_nxt) >= CW'(FETCH_WIDTH);
    end
  end

  circ_ptr #(.DEPTH(DEPTH), .ADD_W(DW)) u_head (
    .clk   (clk),
    .rst   (rst),
    .i_clr (i_squash_vld),
    .i_add (w_n_deq),
    .o_ptr (w_head)
  );

  circ_ptr #(.DEPTH(DEPTH), .ADD_W(NW)) u_tail (
    .clk   (clk),
    .rst   (rst),
    .i_clr (i_squash_vld),
    .i_add (w_n_wr),
    .o_ptr (w_tail)
  );

  assign o_can_enq = r_can_enq;
  assign o_count   = r_count;

  // Fetch must not push into a buffer that has not advertised space.
  a_enq_space: assert property (@(posedge clk) disable iff (rst)
    ((|i_enq_vld) && !i_squash_vld) |-> r_can_enq);

  // Valid lanes must be packed from lane 0 (x & (x+1) clears the low run).
  a_enq_contig: assert property (@(posedge clk) disable iff (rst)
    ((i_enq_vld & (i_enq_vld + FETCH_WIDTH'(1))) == '0));

  // Pointer-derived full/empty must agree with the occupancy counter.
  a_full_cnt: assert property (@(posedge clk) disable iff (rst)
    w_full == (r_count == CW'(DEPTH)));
  a_empty_cnt: assert property (@(posedge clk) disable iff (rst)
    w_empty == (r_count == '0));

endmodule

// File: tb/tb_inst_buffer.sv
// Bench for inst_buffer: a scoreboard queue holds entries in program order;
// drive() applies one cycle of stimulus and updates the model, each test
// task compares DUT outputs against the model inline.
module tb_inst_buffer;
  import inst_buffer_pkg::*;

  localparam int DEPTH = 16;
  localparam int FW    = 4;
  localparam int DW    = 4;
`ifdef INST_BUFFER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    i_squash_vld;
  logic                    i_deq_rdy;
  logic        [FW-1:0]    i_enq_vld;
  fetchEntry_t [FW-1:0]    i_enq_entry;
  logic                    o_can_enq;
  logic        [DW-1:0]    o_deq_vld;
  fetchEntry_t [DW-1:0]    o_deq_entry;
  logic        [4:0]       o_count;

  int          n_err = 0;
  int          n_chk = 0;
  fetchEntry_t sb[$];
  int          m_cnt, m_nxt, next_inst, last_inst;
  logic [DW-1:0] exp_vld;
  fetchEntry_t exp_ent [DW];

  always #5 clk = ~clk;

  inst_buffer #(.DEPTH(DEPTH), .FETCH_WIDTH(FW), .DECODE_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_squash_vld (i_squash_vld),
    .i_enq_vld    (i_enq_vld),
    .i_enq_entry  (i_enq_entry),
    .o_can_enq    (o_can_enq),
    .o_deq_vld    (o_deq_vld),
    .o_deq_entry  (o_deq_entry),
    .i_deq_rdy    (i_deq_rdy),
    .o_count      (o_count)
  );

  function automatic fetchEntry_t mk(input int n);
    fetchEntry_t e;
    e.pc   = 32'h8000_0000 + 32'(n) * 32'd4;
    e.inst = 32'(n);
    return e;
  endfunction

  // One cycle: apply inputs after the edge, then update the reference model.
  task automatic drive(input logic [FW-1:0] vld, input logic rdy, input logic sq);
    int n_enq, n_show;
    bit fire, byp;
    @(posedge clk);
    m_cnt = m_nxt;
    #1;
    i_enq_vld = vld; i_deq_rdy = rdy; i_squash_vld = sq;
    for (int l = 0; l < FW; l++) i_enq_entry[l] = mk(next_inst + l);
    #1;
    fire  = (vld != '0) && ((DEPTH - m_cnt) >= FW) && !sq;
    byp   = BYP && (m_cnt == 0) && !sq;
    n_enq = fire ? $countones(vld) : 0;
    for (int l = 0; l < n_enq; l++) sb.push_back(mk(next_inst + l));
    exp_vld = '0;
    for (int i = 0; i < DW; i++) exp_vld[i] = byp ? vld[i] : (m_cnt > i);
    n_show = $countones(exp_vld);
    for (int i = 0; i < DW; i++) exp_ent[i] = (i < n_show) ? sb[i] : '0;
    if (sq) begin
      sb.delete(); m_nxt = 0; next_inst += FW;
    end else begin
      if (rdy) for (int i = 0; i < n_show; i++) void'(sb.pop_front());
      m_nxt = m_cnt + n_enq - (rdy ? n_show : 0);
      next_inst += n_enq;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_nxt = 0; sb.delete();
    for (int c = 0; c < 5; c++) begin
      drive('0, 1'b0, 1'b0);
      n_chk++; if (o_count !== 5'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", o_count); end
      n_chk++; if (o_can_enq !== 1'b1) begin n_err++; $display("FAIL reset_can_enq got %b want 1", o_can_enq); end
      n_chk++; if (o_deq_vld !== 4'b0000) begin n_err++; $display("FAIL reset_vld got %b want 0000", o_deq_vld); end
    end
  endtask

  task automatic test_fill();
    next_inst = 'h100;
    repeat (4) drive(4'hF, 1'b0, 1'b0);
    drive(4'h0, 1'b0, 1'b0);
    n_chk++; if (o_count !== 5'd16) begin n_err++; $display("FAIL fill_count got %0d want 16", o_count); end
    n_chk++; if (o_can_enq !== 1'b0) begin n_err++; $display("FAIL fill_can_enq got %b want 0", o_can_enq); end
    n_chk++; if (o_deq_vld !== 4'hF) begin n_err++; $display("FAIL fill_vld got %b want 1111", o_deq_vld); end
    for (int i = 0; i < DW; i++) begin
      n_chk++;
      if (o_deq_entry[i].inst !== 32'h100 + 32'(i)) begin
        n_err++; $display("FAIL fill_lane%0d got %h want %h", i, o_deq_entry[i].inst, 32'h100 + 32'(i));
      end
    end
  endtask

  task automatic test_drain();
    last_inst = 'h0FF;
    for (int c = 0; c < 26; c++) begin
      if (c < 24) drive(((DEPTH - m_nxt) >= FW) ? 4'b0111 : 4'b0000, 1'b1, 1'b0);
      else        drive(4'b0000, 1'b1, 1'b0);
      n_chk++; if (o_count !== 5'(m_cnt)) begin n_err++; $display("FAIL drain_count cyc%0d got %0d want %0d", c, o_count, m_cnt); end
      n_chk++; if (o_can_enq !== ((DEPTH - m_cnt) >= FW)) begin n_err++; $display("FAIL drain_can_enq cyc%0d got %b", c, o_can_enq); end
      n_chk++; if (o_deq_vld !== exp_vld) begin n_err++; $display("FAIL drain_vld cyc%0d got %b want %b", c, o_deq_vld, exp_vld); end
      for (int i = 0; i < DW; i++) if (exp_vld[i]) begin
        n_chk++;
        if (o_deq_entry[i] !== exp_ent[i]) begin
          n_err++; $display("FAIL drain_lane%0d cyc%0d got %h want %h", i, c, o_deq_entry[i], exp_ent[i]);
        end
        n_chk++;
        if (o_deq_entry[i].inst !== 32'(last_inst + 1)) begin
          n_err++; $display("FAIL drain_seq cyc%0d got %h want %h", c, o_deq_entry[i].inst, last_inst + 1);
        end
        last_inst = last_inst + 1;
      end
    end
    drive('0, 1'b0, 1'b0);
    n_chk++; if (o_count !== 5'd0) begin n_err++; $display("FAIL drain_empty got %0d want 0", o_count); end
  endtask

  task automatic test_partial();
    drive(4'b0011, 1'b0, 1'b0);
    n_chk++; if (o_deq_vld !== exp_vld) begin n_err++; $display("FAIL part_vld0 got %b want %b", o_deq_vld, exp_vld); end
    drive(4'b0000, 1'b1, 1'b0);
    n_chk++; if (o_deq_vld !== 4'b0011) begin n_err++; $display("FAIL part_vld got %b want 0011", o_deq_vld); end
    n_chk++; if (o_count !== 5'd2) begin n_err++; $display("FAIL part_count got %0d want 2", o_count); end
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (o_deq_entry[i] !== exp_ent[i]) begin n_err++; $display("FAIL part_lane%0d got %h want %h", i, o_deq_entry[i], exp_ent[i]); end
    end
    drive('0, 1'b0, 1'b0);
    n_chk++; if (o_count !== 5'd0) begin n_err++; $display("FAIL part_drained got %0d want 0", o_count); end
  endtask

  task automatic test_squash();
    drive(4'hF, 1'b0, 1'b0);
    drive(4'hF, 1'b0, 1'b0);
    drive(4'b0011, 1'b0, 1'b0);
    drive('0, 1'b0, 1'b0);
    n_chk++; if (o_count !== 5'd10) begin n_err++; $display("FAIL sq_pre_count got %0d want 10", o_count); end
    drive(4'hF, 1'b1, 1'b1);
    drive('0, 1'b0, 1'b0);
    n_chk++; if (o_count !== 5'd0) begin n_err++; $display("FAIL sq_count got %0d want 0", o_count); end
    n_chk++; if (o_deq_vld !== 4'b0000) begin n_err++; $display("FAIL sq_vld got %b want 0000", o_deq_vld); end
    n_chk++; if (o_can_enq !== 1'b1) begin n_err++; $display("FAIL sq_can_enq got %b want 1", o_can_enq); end
    drive(4'hF, 1'b1, 1'b1);
    drive(4'hF, 1'b0, 1'b1);
    drive('0, 1'b0, 1'b0);
    n_chk++; if (o_count !== 5'd0) begin n_err++; $display("FAIL sq_hold got %0d want 0", o_count); end
    drive(4'b0011, 1'b0, 1'b0);
    drive('0, 1'b1, 1'b0);
    n_chk++; if (o_deq_vld !== 4'b0011) begin n_err++; $display("FAIL sq_post_vld got %b want 0011", o_deq_vld); end
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (o_deq_entry[i] !== exp_ent[i]) begin n_err++; $display("FAIL sq_post_lane%0d got %h want %h", i, o_deq_entry[i], exp_ent[i]); end
    end
    drive('0, 1'b0, 1'b0);
  endtask

  task automatic test_bypass();
    drive(4'b0011, 1'b1, 1'b0);
    n_chk++;
    if (o_deq_vld !== (BYP ? 4'b0011 : 4'b0000)) begin
      n_err++; $display("FAIL byp_same_vld got %b want %b", o_deq_vld, BYP ? 4'b0011 : 4'b0000);
    end
    for (int i = 0; i < DW; i++) if (exp_vld[i]) begin
      n_chk++;
      if (o_deq_entry[i] !== exp_ent[i]) begin n_err++; $display("FAIL byp_lane%0d got %h want %h", i, o_deq_entry[i], exp_ent[i]); end
    end
    drive('0, 1'b1, 1'b0);
    n_chk++; if (o_count !== (BYP ? 5'd0 : 5'd2)) begin n_err++; $display("FAIL byp_count got %0d want %0d", o_count, BYP ? 0 : 2); end
    n_chk++; if (o_deq_vld !== (BYP ? 4'b0000 : 4'b0011)) begin n_err++; $display("FAIL byp_next_vld got %b", o_deq_vld); end
    for (int i = 0; i < DW; i++) if (exp_vld[i]) begin
      n_chk++;
      if (o_deq_entry[i] !== exp_ent[i]) begin n_err++; $display("FAIL byp_next_lane%0d got %h want %h", i, o_deq_entry[i], exp_ent[i]); end
    end
    drive('0, 1'b0, 1'b0);
    n_chk++; if (o_count !== 5'd0) begin n_err++; $display("FAIL byp_end got %0d want 0", o_count); end
  endtask

  task automatic test_reset_mid();
    drive(4'hF, 1'b0, 1'b0);
    drive(4'hF, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1; i_enq_vld = 4'hF; i_deq_rdy = 1'b1; i_squash_vld = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0; i_enq_vld = '0; i_deq_rdy = 1'b0;
    m_nxt = 0; sb.delete();
    #1;
    n_chk++; if (o_count !== 5'd0) begin n_err++; $display("FAIL rstmid_count got %0d want 0", o_count); end
    n_chk++; if (o_deq_vld !== 4'b0000) begin n_err++; $display("FAIL rstmid_vld got %b want 0000", o_deq_vld); end
    n_chk++; if (o_can_enq !== 1'b1) begin n_err++; $display("FAIL rstmid_can_enq got %b want 1", o_can_enq); end
    drive('0, 1'b0, 1'b0);
    n_chk++; if (o_count !== 5'd0) begin n_err++; $display("FAIL rstmid_hold got %0d want 0", o_count); end
  endtask

  initial begin
    rst = 1'b1; i_squash_vld = 1'b0; i_deq_rdy = 1'b0; i_enq_vld = '0; i_enq_entry = '0;
    m_cnt = 0; m_nxt = 0; next_inst = 0; last_inst = 0; exp_vld = '0;
    test_reset();
    test_fill();
    test_drain();
    test_partial();
    test_squash();
    test_bypass();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
